// File: rtl/seq_loop_status_monitor_pkg.sv
// Shared types and default sizes for the loop/transaction status monitor.
package seq_loop_status_monitor_pkg;

    localparam int DEF_STATE_W = 84;
    localparam int DEF_CNT_W   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } txn_state_t;

    typedef enum logic {
        OUT     = 1'b0,
        IN_LOOP = 1'b1
    } loop_state_t;

endpackage

// File: rtl/seq_loop_status_monitor_sat_counter.sv
// Saturating counter: clear wins over load-to-one, which wins over increment.
module sat_counter
    import seq_loop_status_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             load1,
    output logic [CNT_W-1:0] count_r
);

    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};

    // Count register; holds at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= ZERO_C;
        end else if (clear) begin
            count_r <= ZERO_C;
        end else if (load1) begin
            count_r <= ONE_C;
        end else if (inc && (count_r != MAX_C)) begin
            count_r <= count_r + ONE_C;
        end
    end

endmodule

// File: rtl/seq_loop_status_monitor.sv
// Observes an ap_* handshake block and its one-hot FSM, reporting transaction
// and loop/iteration statistics. Everything freezes once finish is seen.
module seq_loop_status_monitor
    import seq_loop_status_monitor_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic               finish,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] pre_loop_state,
    input  logic [STATE_W-1:0] post_loop_state,
    input  logic [STATE_W-1:0] quit_loop_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic               pre_states_valid,
    input  logic               post_states_valid,
    input  logic               quit_states_valid,
    input  logic               iter_end_states_valid,
    input  logic               one_state_loop,
    input  logic               one_state_block,
    output logic               txn_busy,
    output logic [CNT_W-1:0]   txn_count,
    output logic [CNT_W-1:0]   txn_latency,
    output logic               loop_active,
    output logic [CNT_W-1:0]   loop_entries,
    output logic [CNT_W-1:0]   iter_count,
    output logic [CNT_W-1:0]   iter_latency,
    output logic [CNT_W-1:0]   loop_latency,
    output logic               loop_exit_pulse,
    output logic               monitor_done
);

    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};

    // ap_ready and one_state_block carry no information this monitor uses.
    logic unused_inputs_s;
    assign unused_inputs_s = ap_ready ^ one_state_block;

    txn_state_t         txn_state_r, txn_state_s;
    loop_state_t        loop_state_r, loop_state_s;
    logic [STATE_W-1:0] prev_state_r;
    logic               monitor_done_r, active_s;
    logic [CNT_W-1:0]   txn_run_s, loop_run_s, iter_run_s;
    logic [CNT_W-1:0]   txn_latency_r, iter_latency_r, loop_latency_r;
    logic [CNT_W-1:0]   txn_lat_s, iter_lat_s;
    logic               loop_exit_pulse_r;
    logic               txn_close_s, txn_load_s, txn_inc_s;
    logic               entry_s, exit_s, loop_entry_s, loop_exit_s, in_loop_s;
    logic               start_hit_s, start_prev_s, end_prev_s, end_cur_s;
    logic               iter_done_s, iter_start_s;

    // Once finish is seen (including its own cycle) nothing may change.
    assign active_s  = !finish && !monitor_done_r;
    assign in_loop_s = (loop_state_r == IN_LOOP);

    // Full-vector state compares; a compare with its valid bit low is false.
    assign start_hit_s  = (cur_state == iter_start_state);
    assign start_prev_s = (prev_state_r == iter_start_state);
    assign end_prev_s   = iter_end_states_valid && (prev_state_r == iter_end_state);
    assign end_cur_s    = iter_end_states_valid && (cur_state == iter_end_state);
    assign entry_s      = pre_states_valid && (prev_state_r == pre_loop_state) && start_hit_s;
    assign exit_s       = quit_states_valid && (prev_state_r == quit_loop_state)
                          && post_states_valid && (cur_state == post_loop_state);

    // Transaction FSM next state; the running counter holds cycles so far, so
    // the done cycle itself is accounted for by a saturating +1.
    always_comb begin
        txn_state_s = txn_state_r;
        txn_close_s = 1'b0;
        txn_load_s  = 1'b0;
        txn_inc_s   = 1'b0;
        txn_lat_s   = ZERO_C;
        case (txn_state_r)
            IDLE: begin
                if (ap_start && ap_done && ap_continue) begin
                    txn_close_s = 1'b1;
                    txn_lat_s   = ONE_C;
                end else if (ap_start) begin
                    txn_state_s = BUSY;
                    txn_load_s  = 1'b1;
                end else begin
                    txn_state_s = IDLE;
                end
            end
            BUSY: begin
                if (ap_done && ap_continue) begin
                    txn_close_s = 1'b1;
                    txn_lat_s   = (txn_run_s == MAX_C) ? MAX_C : (txn_run_s + ONE_C);
                    if (ap_start) begin
                        txn_load_s = 1'b1;
                    end else begin
                        txn_state_s = IDLE;
                    end
                end else begin
                    txn_inc_s = 1'b1;
                end
            end
            default: begin
                txn_state_s = IDLE;
            end
        endcase
    end

    // Loop FSM next state; a simultaneous exit and entry re-enters at once.
    always_comb begin
        loop_state_s = loop_state_r;
        loop_entry_s = 1'b0;
        loop_exit_s  = 1'b0;
        case (loop_state_r)
            OUT: begin
                if (entry_s) begin
                    loop_state_s = IN_LOOP;
                    loop_entry_s = 1'b1;
                end else begin
                    loop_state_s = OUT;
                end
            end
            IN_LOOP: begin
                if (exit_s) begin
                    loop_exit_s  = 1'b1;
                    loop_entry_s = entry_s;
                    loop_state_s = entry_s ? IN_LOOP : OUT;
                end else begin
                    loop_state_s = IN_LOOP;
                end
            end
            default: begin
                loop_state_s = OUT;
            end
        endcase
    end

    // Iteration boundaries; a one-state loop completes on every start-state cycle.
    always_comb begin
        iter_start_s = loop_entry_s || (in_loop_s && start_hit_s && !start_prev_s);
        if (one_state_loop) begin
            iter_done_s = in_loop_s && start_hit_s;
            iter_lat_s  = ONE_C;
        end else begin
            iter_done_s = in_loop_s && end_prev_s && !end_cur_s;
            iter_lat_s  = iter_run_s;
        end
    end

    // State, history and result registers, all held while frozen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            txn_state_r       <= IDLE;
            loop_state_r      <= OUT;
            prev_state_r      <= {STATE_W{1'b0}};
            txn_latency_r     <= ZERO_C;
            iter_latency_r    <= ZERO_C;
            loop_latency_r    <= ZERO_C;
            loop_exit_pulse_r <= 1'b0;
        end else if (active_s) begin
            txn_state_r       <= txn_state_s;
            loop_state_r      <= loop_state_s;
            prev_state_r      <= cur_state;
            loop_exit_pulse_r <= loop_exit_s;
            if (txn_close_s) begin
                txn_latency_r <= txn_lat_s;
            end
            if (iter_done_s) begin
                iter_latency_r <= iter_lat_s;
            end
            if (loop_exit_s) begin
                loop_latency_r <= loop_run_s;
            end
        end
    end

    // Sticky end-of-observation flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            monitor_done_r <= 1'b0;
        end else begin
            monitor_done_r <= monitor_done_r | finish;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_txn_run (
        .clock(clock), .reset(reset), .clear(1'b0),
        .inc(active_s && txn_inc_s), .load1(active_s && txn_load_s),
        .count_r(txn_run_s)
    );

    sat_counter #(.CNT_W(CNT_W)) u_txn_count (
        .clock(clock), .reset(reset), .clear(1'b0),
        .inc(active_s && txn_close_s), .load1(1'b0),
        .count_r(txn_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_loop_entries (
        .clock(clock), .reset(reset), .clear(1'b0),
        .inc(active_s && loop_entry_s), .load1(1'b0),
        .count_r(loop_entries)
    );

    sat_counter #(.CNT_W(CNT_W)) u_iter_count (
        .clock(clock), .reset(reset), .clear(1'b0),
        .inc(active_s && iter_done_s), .load1(1'b0),
        .count_r(iter_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_loop_run (
        .clock(clock), .reset(reset), .clear(1'b0),
        .inc(active_s && in_loop_s && !loop_entry_s), .load1(active_s && loop_entry_s),
        .count_r(loop_run_s)
    );

    sat_counter #(.CNT_W(CNT_W)) u_iter_run (
        .clock(clock), .reset(reset), .clear(1'b0),
        .inc(active_s && in_loop_s && !iter_start_s), .load1(active_s && iter_start_s),
        .count_r(iter_run_s)
    );

    assign txn_busy        = (txn_state_r == BUSY);
    assign loop_active     = (loop_state_r == IN_LOOP);
    assign txn_latency     = txn_latency_r;
    assign iter_latency    = iter_latency_r;
    assign loop_latency    = loop_latency_r;
    assign loop_exit_pulse = loop_exit_pulse_r;
    assign monitor_done    = monitor_done_r;

endmodule

// File: tb/tb_seq_loop_status_monitor.sv
// Scoreboard bench: stimulus pushes expected transaction / loop-exit results,
// a monitor pops and compares whenever the DUT reports a completion.
module tb_seq_loop_status_monitor;

    localparam int STATE_W = 84;
    localparam int CNT_W   = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic               ap_start, ap_ready, ap_done, ap_continue, finish;
    logic [STATE_W-1:0] cur_state, pre_loop_state, post_loop_state, quit_loop_state;
    logic [STATE_W-1:0] iter_start_state, iter_end_state;
    logic               pre_states_valid, post_states_valid, quit_states_valid, iter_end_states_valid;
    logic               one_state_loop, one_state_block;
    logic               txn_busy, loop_active, loop_exit_pulse, monitor_done;
    logic [CNT_W-1:0]   txn_count, txn_latency, loop_entries, iter_count;
    logic [CNT_W-1:0]   iter_latency, loop_latency;

    typedef struct { int cnt; int lat; bit busy; } txn_exp_t;
    typedef struct { int entries; int iters; int iter_lat; int loop_lat; } loop_exp_t;

    txn_exp_t  txn_q[$];
    loop_exp_t loop_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    seq_loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish), .cur_state(cur_state),
        .pre_loop_state(pre_loop_state), .post_loop_state(post_loop_state),
        .quit_loop_state(quit_loop_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state),
        .pre_states_valid(pre_states_valid), .post_states_valid(post_states_valid),
        .quit_states_valid(quit_states_valid), .iter_end_states_valid(iter_end_states_valid),
        .one_state_loop(one_state_loop), .one_state_block(one_state_block),
        .txn_busy(txn_busy), .txn_count(txn_count), .txn_latency(txn_latency),
        .loop_active(loop_active), .loop_entries(loop_entries), .iter_count(iter_count),
        .iter_latency(iter_latency), .loop_latency(loop_latency),
        .loop_exit_pulse(loop_exit_pulse), .monitor_done(monitor_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [STATE_W-1:0] st(input int k);
        logic [STATE_W-1:0] one_v;
        one_v = {{(STATE_W-1){1'b0}}, 1'b1};
        return (k == 0) ? {STATE_W{1'b0}} : (one_v << (k - 1));
    endfunction

    task automatic drive_state(input int k);
        cur_state = st(k);
        tick();
    endtask

    // s1, s2..s84, s2..s84, s2, s1, idle
    task automatic play_loop();
        drive_state(1);
        for (int k = 2; k <= 84; k++) drive_state(k);
        for (int k = 2; k <= 84; k++) drive_state(k);
        drive_state(2);
        drive_state(1);
        drive_state(0);
        drive_state(0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    txn_busy, 0);
        check({tag, "_tcount"},  txn_count, 0);
        check({tag, "_tlat"},    txn_latency, 0);
        check({tag, "_lactive"}, loop_active, 0);
        check({tag, "_entries"}, loop_entries, 0);
        check({tag, "_iters"},   iter_count, 0);
        check({tag, "_ilat"},    iter_latency, 0);
        check({tag, "_llat"},    loop_latency, 0);
        check({tag, "_pulse"},   loop_exit_pulse, 0);
        check({tag, "_done"},    monitor_done, 0);
    endtask

    // Monitor: completion events are a rising txn_count or a loop exit pulse.
    initial begin
        int last_cnt;
        last_cnt = 0;
        forever begin
            @(posedge clock);
            #2;
            if (!reset) begin
                last_cnt = 0;
            end else begin
                if (int'(txn_count) != last_cnt) begin
                    last_cnt = int'(txn_count);
                    if (txn_q.size() == 0) begin
                        check("txn_unexpected", 1, 0);
                    end else begin
                        txn_exp_t e;
                        e = txn_q.pop_front();
                        check("txn_count", txn_count, e.cnt);
                        check("txn_latency", txn_latency, e.lat);
                        check("txn_busy", txn_busy, e.busy);
                    end
                end
                if (loop_exit_pulse) begin
                    if (loop_q.size() == 0) begin
                        check("loop_unexpected_pulse", 1, 0);
                    end else begin
                        loop_exp_t l;
                        l = loop_q.pop_front();
                        check("loop_entries", loop_entries, l.entries);
                        check("iter_count", iter_count, l.iters);
                        check("iter_latency", iter_latency, l.iter_lat);
                        check("loop_latency", loop_latency, l.loop_lat);
                        check("loop_active_after_exit", loop_active, 0);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0; ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
        finish = 1'b0; cur_state = st(0);
        pre_loop_state = st(1); post_loop_state = st(1); quit_loop_state = st(2);
        iter_start_state = st(2); iter_end_state = st(84);
        pre_states_valid = 1'b1; post_states_valid = 1'b1; quit_states_valid = 1'b1;
        iter_end_states_valid = 1'b1; one_state_loop = 1'b0; one_state_block = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Start, three cycles later done: latency 4, idle afterwards.
        txn_q.push_back('{cnt: 1, lat: 4, busy: 1'b0});
        ap_start = 1'b1; ap_ready = 1'b1; tick();
        ap_start = 1'b0; ap_ready = 1'b0; tick(); tick();
        ap_done = 1'b1; ap_continue = 1'b1; tick();
        ap_done = 1'b0; ap_continue = 1'b0;
        check("busy_after_done", txn_busy, 0);

        // Start and done together while idle.
        txn_q.push_back('{cnt: 2, lat: 1, busy: 1'b0});
        ap_start = 1'b1; ap_done = 1'b1; ap_continue = 1'b1; tick();
        ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b0;
        check("busy_same_cycle", txn_busy, 0);

        // Back-to-back: done+start while busy, then an ignored start / stalled done.
        txn_q.push_back('{cnt: 3, lat: 3, busy: 1'b1});
        txn_q.push_back('{cnt: 4, lat: 3, busy: 1'b0});
        ap_start = 1'b1; tick();
        ap_start = 1'b0; tick();
        ap_start = 1'b1; ap_done = 1'b1; ap_continue = 1'b1; tick();
        ap_continue = 1'b0; tick();
        check("busy_held_b2b", txn_busy, 1);
        check("count_no_continue", txn_count, 3);
        ap_start = 1'b0; ap_continue = 1'b1; tick();
        ap_done = 1'b0; ap_continue = 1'b0;

        // Pre-state compare disabled: loop never entered.
        pre_states_valid = 1'b0;
        play_loop();
        check("entries_pre_invalid", loop_entries, 0);
        check("iters_pre_invalid", iter_count, 0);
        pre_states_valid = 1'b1;

        // Two full iterations then exit.
        loop_q.push_back('{entries: 1, iters: 2, iter_lat: 83, loop_lat: 167});
        play_loop();

        // Reset during the second iteration, then replay from scratch.
        drive_state(1);
        for (int k = 2; k <= 84; k++) drive_state(k);
        for (int k = 2; k <= 40; k++) drive_state(k);
        check("active_mid_loop", loop_active, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        tick();
        cur_state = st(0);
        reset = 1'b1;
        tick();
        loop_q.push_back('{entries: 1, iters: 2, iter_lat: 83, loop_lat: 167});
        play_loop();

        // Finish while busy freezes everything.
        ap_start = 1'b1; tick();
        ap_start = 1'b0; tick();
        finish = 1'b1; tick();
        finish = 1'b0; ap_done = 1'b1; ap_continue = 1'b1; drive_state(1); drive_state(2);
        ap_done = 1'b0; ap_continue = 1'b0; tick();
        check("monitor_done", monitor_done, 1);
        check("frozen_busy", txn_busy, 1);
        check("frozen_count", txn_count, 0);
        check("frozen_latency", txn_latency, 0);
        check("frozen_entries", loop_entries, 1);
        check("frozen_active", loop_active, 0);

        tick(); tick();
        check("txn_queue_drained", txn_q.size(), 0);
        check("loop_queue_drained", loop_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
